// File: rtl/priority_pkg.sv
// Shared definitions for the priority encoder/decoder pair.
package priority_pkg;

    localparam int IN_W  = 3;
    localparam int OUT_W = 2 ** IN_W;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } fifo_state_e;

    // Index to one-hot word; every index value is a legal code.
    function automatic logic [OUT_W-1:0] onehot_decode(input logic [IN_W-1:0] idx);
        logic [OUT_W-1:0] word;
        word      = '0;
        word[idx] = 1'b1;
        return word;
    endfunction

endpackage

// File: rtl/dec_fifo2.sv
// Two-entry valid/ready FIFO: occupancy state, 1-bit pointers and storage.
module dec_fifo2
    import priority_pkg::*;
#(
    parameter int W = IN_W
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    output logic         full_o,
    output logic [W-1:0] data_o
);

    fifo_state_e  state_q;
    logic         rd_ptr_q;
    logic         wr_ptr_q;
    logic [W-1:0] mem_q [2];
    logic         push;
    logic         pop;

    assign push    = push_i && (state_q != FULL);
    assign pop     = pop_i && (state_q != EMPTY);
    assign valid_o = (state_q != EMPTY);
    assign full_o  = (state_q == FULL);
    assign data_o  = mem_q[rd_ptr_q];

    // Occupancy FSM, pointer wrap and storage write.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= EMPTY;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            mem_q[0] <= '0;
            mem_q[1] <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case (state_q)
                EMPTY: if (push) state_q <= ONE;
                ONE: begin
                    if (push && !pop)      state_q <= FULL;
                    else if (pop && !push) state_q <= EMPTY;
                end
                FULL:  if (pop) state_q <= ONE;
                default: state_q <= EMPTY;
            endcase
        end
    end

endmodule

// File: rtl/priority_decoder.sv
// Registered 3-to-8 decoder with 2-deep input buffering and a sticky delivery mask.
module priority_decoder #(
    parameter int IN_W  = priority_pkg::IN_W,
    parameter int OUT_W = 2 ** IN_W
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Enable,
    input  logic [IN_W-1:0]  In,
    input  logic             In_Valid,
    output logic             In_Ready,
    output logic [OUT_W-1:0] Out,
    output logic             Out_Valid,
    input  logic             Out_Ready,
    output logic [OUT_W-1:0] Mask,
    input  logic             Mask_Clear
);
    import priority_pkg::*;

    logic             fifo_full;
    logic             push;
    logic             pop;
    logic [IN_W-1:0]  head;
    logic [OUT_W-1:0] head_onehot;
    logic [OUT_W-1:0] mask_d;
    logic [OUT_W-1:0] mask_q;

    // Ready depends only on Enable and registered occupancy, never on Out_Ready.
    assign In_Ready = Enable && !fifo_full;
    assign push     = In_Valid && In_Ready;
    assign pop      = Out_Valid && Out_Ready;

    dec_fifo2 #(
        .W(IN_W)
    ) u_fifo (
        .clk_i  (Clk),
        .rst_ni (Reset_n),
        .push_i (push),
        .pop_i  (pop),
        .data_i (In),
        .valid_o(Out_Valid),
        .full_o (fifo_full),
        .data_o (head)
    );

    // The package decoder is fixed at the shared width; other widths use a shift.
    if (IN_W == priority_pkg::IN_W) begin : g_pkg_dec
        assign head_onehot = onehot_decode(head);
    end else begin : g_shift_dec
        assign head_onehot = {{(OUT_W-1){1'b0}}, 1'b1} << head;
    end

    assign Out  = Out_Valid ? head_onehot : '0;
    assign Mask = mask_q;

    // Next mask: a clear coinciding with a pop keeps the popped bit.
    always_comb begin
        mask_d = mask_q;
        if (Mask_Clear) begin
            mask_d = pop ? Out : '0;
        end else if (pop) begin
            mask_d = mask_q | Out;
        end
    end

    // Sticky mask register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            mask_q <= '0;
        end else begin
            mask_q <= mask_d;
        end
    end

endmodule

// File: tb/tb_priority_decoder.sv
// Scoreboard bench for priority_decoder: driver queues expected one-hot words, monitor retires them.
module tb_priority_decoder;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       Enable = 1'b0;
    logic [2:0] In = '0;
    logic       In_Valid = 1'b0;
    logic       In_Ready;
    logic [7:0] Out;
    logic       Out_Valid;
    logic       Out_Ready = 1'b0;
    logic [7:0] Mask;
    logic       Mask_Clear = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int pops     = 0;

    logic [7:0] exp_q[$];
    logic [7:0] exp_mask = 8'h00;

    priority_decoder #(
        .IN_W (3),
        .OUT_W(8)
    ) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .Enable    (Enable),
        .In        (In),
        .In_Valid  (In_Valid),
        .In_Ready  (In_Ready),
        .Out       (Out),
        .Out_Valid (Out_Valid),
        .Out_Ready (Out_Ready),
        .Mask      (Mask),
        .Mask_Clear(Mask_Clear)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model contents are discarded the moment reset asserts.
    always @(negedge Reset_n) begin
        exp_q.delete();
        exp_mask = 8'h00;
    end

    // Monitor: compare against the model between edges, retire popped words, track mask.
    always @(negedge Clk) begin
        if (Reset_n) begin
            logic [7:0] head;
            logic       do_pop;
            head = (exp_q.size() != 0) ? exp_q[0] : 8'h00;
            check("in_ready", In_Ready, Enable && (exp_q.size() < 2));
            check("out_valid", Out_Valid, exp_q.size() != 0);
            check("out", Out, head);
            check("mask", Mask, exp_mask);
            do_pop = (exp_q.size() != 0) && Out_Ready;
            if (Mask_Clear)  exp_mask = do_pop ? head : 8'h00;
            else if (do_pop) exp_mask = exp_mask | head;
            if (do_pop) begin
                void'(exp_q.pop_front());
                pops++;
            end
        end
    end

    // One clock: observe acceptance mid-cycle, queue the expected word just after the edge.
    task automatic step();
        logic       acc;
        logic [2:0] idx;
        @(negedge Clk);
        acc = Reset_n && Enable && In_Valid && In_Ready;
        idx = In;
        @(posedge Clk);
        #1;
        if (acc && Reset_n) exp_q.push_back(8'd1 << idx);
    endtask

    task automatic offer(input logic [2:0] idx);
        In       = idx;
        In_Valid = 1'b1;
        step();
    endtask

    initial begin
        int pops_before;

        // Reset values while held in reset.
        Enable = 1'b1;
        #3;
        check("rst_out", Out, 8'h00);
        check("rst_out_valid", Out_Valid, 1'b0);
        check("rst_mask", Mask, 8'h00);
        check("rst_in_ready_en1", In_Ready, 1'b1);
        Enable = 1'b0;
        #1;
        check("rst_in_ready_en0", In_Ready, 1'b0);
        Enable = 1'b1;
        #18;
        Reset_n = 1'b1;
        @(posedge Clk);
        #1;

        // Single index, one-cycle latency.
        Out_Ready = 1'b1;
        offer(3'd5);
        In_Valid = 1'b0;
        check("t1_out", Out, 8'h20);
        check("t1_out_valid", Out_Valid, 1'b1);
        step();
        check("t1_mask", Mask, 8'h20);
        check("t1_empty", Out_Valid, 1'b0);

        // Backpressure until full, third offer refused, then drain in order.
        Out_Ready = 1'b0;
        offer(3'd0);
        offer(3'd7);
        check("t2_full_in_ready", In_Ready, 1'b0);
        offer(3'd3);
        In_Valid  = 1'b0;
        Out_Ready = 1'b1;
        step();
        step();
        step();
        check("t2_drained", Out_Valid, 1'b0);
        check("t2_mask", Mask, 8'hA1);

        // Back-to-back stream 0..7 with no bubbles.
        pops_before = pops;
        for (int i = 0; i < 8; i++) offer(3'(i));
        In_Valid = 1'b0;
        step();
        check("t3_pop_count", 8'(pops - pops_before), 8'd8);
        step();
        check("t3_mask", Mask, 8'hFF);

        // Clear coinciding with a pop keeps the popped bit; clear alone zeroes.
        Out_Ready = 1'b0;
        offer(3'd2);
        In_Valid   = 1'b0;
        Out_Ready  = 1'b1;
        Mask_Clear = 1'b1;
        step();
        check("t4_clear_pop", Mask, 8'h04);
        step();
        check("t4_clear_only", Mask, 8'h00);
        Mask_Clear = 1'b0;

        // Enable dropped with two entries buffered: both still delivered.
        Out_Ready = 1'b0;
        offer(3'd1);
        offer(3'd6);
        Enable = 1'b0;
        In     = 3'd3;
        #1;
        check("t5_in_ready_full", In_Ready, 1'b0);
        Out_Ready = 1'b1;
        step();
        check("t5_in_ready_one", In_Ready, 1'b0);
        check("t5_second_out", Out, 8'h40);
        step();
        step();
        check("t5_drained", Out_Valid, 1'b0);
        Enable   = 1'b1;
        In_Valid = 1'b0;

        // Reset pulsed mid-cycle with two entries buffered.
        Out_Ready = 1'b0;
        offer(3'd4);
        offer(3'd3);
        In_Valid = 1'b0;
        #2;
        Reset_n = 1'b0;
        #1;
        check("t6_out_valid", Out_Valid, 1'b0);
        check("t6_out", Out, 8'h00);
        check("t6_mask", Mask, 8'h00);
        #12;
        Reset_n = 1'b1;
        @(posedge Clk);
        #1;
        Out_Ready = 1'b1;
        step();
        step();
        check("t6_no_stale", Out_Valid, 1'b0);
        check("t6_mask_after", Mask, 8'h00);

        // Randomised traffic against the scoreboard.
        for (int i = 0; i < 400; i++) begin
            Enable     = ($urandom_range(7) != 0);
            In_Valid   = ($urandom_range(3) != 0);
            In         = 3'($urandom_range(7));
            Out_Ready  = ($urandom_range(2) != 0);
            Mask_Clear = ($urandom_range(15) == 0);
            step();
        end
        Enable     = 1'b1;
        In_Valid   = 1'b0;
        Out_Ready  = 1'b1;
        Mask_Clear = 1'b0;
        step();
        step();
        step();
        check("final_drained", Out_Valid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/priority_decoder.md
# priority_decoder

Registered 3-to-8 decoder: the inverse path of the team's 8-to-3 priority encoder. It accepts a 3-bit index with a valid/ready handshake and buffers it in a 2-entry FIFO. It presents the index as an 8-bit one-hot word with its own valid/ready handshake, and keeps a sticky mask of every index delivered. It sits downstream of the encoder and re-expands encoded grant/interrupt indices into one-hot select lines for the consumer logic.

## Interface
- `IN_W`, default 3: index width.
- `OUT_W`, default `2**IN_W` = 8: one-hot width. Derived; never overridden independently.
- `Clk`  in  1: single clock, rising edge.
- `Reset_n`  in  1: asynchronous, active-low reset.
- `Enable`  in  1: when low, the input side accepts nothing. The output side keeps draining.
- `In`  in  IN_W: index to decode.
- `In_Valid`  in  1: `In` is valid.
- `In_Ready`  out  1: the block can accept `In` this cycle.
- `Out`  out  OUT_W: one-hot decode of the FIFO head entry; all zeros when the FIFO is empty.
- `Out_Valid`  out  1: `Out` is valid.
- `Out_Ready`  in  1: the consumer takes `Out` this cycle.
- `Mask`  out  OUT_W: sticky OR of every one-hot word popped since reset or since the last clear.
- `Mask_Clear`  in  1: synchronous clear of `Mask`.

## Operation
- Push: occurs when `Enable & In_Valid & In_Ready` are all high. `In` is written at the FIFO tail.
- Pop: occurs when `Out_Valid & Out_Ready` are both high. The head entry is removed.
- `In_Ready` = `Enable & (state != FULL)`. It depends on registered state only; there is no combinational path from `Out_Ready`.
- `Out_Valid` = `(state != EMPTY)`. `Out` = `1 << head` when valid, otherwise 0.
- FIFO states are EMPTY, ONE and FULL. Transitions:
  - EMPTY: a push goes to ONE.
  - ONE: a push alone goes to FULL; a pop alone goes to EMPTY; a push and a pop together stay in ONE, with the new entry becoming the head.
  - FULL: a pop goes to ONE. A push is impossible because `In_Ready` is 0.
- Storage: two IN_W-bit entries with a 1-bit read pointer and a 1-bit write pointer. Both pointers wrap modulo 2.
- Mask update, next value in priority order:
  - `Mask_Clear` with a pop: `Out`. The popped bit survives the clear.
  - `Mask_Clear` without a pop: 0.
  - Pop without a clear: `Mask | Out`.
  - Otherwise: hold.
- `Enable` falling while entries are buffered: the buffered entries are still delivered, and no entry is dropped or duplicated.
- Width rule: every IN_W-bit code is legal, so the decoder has no invalid-input case. `Out` is always exactly one-hot when valid and 0 otherwise.

## Timing
- Reset values (async assert, `Reset_n` = 0):
  - state EMPTY, both pointers 0, storage 0.
  - `Out` = 0, `Out_Valid` = 0, `Mask` = 0.
  - `In_Ready` = `Enable`. It is combinational on `Enable`, since the state is EMPTY.
- Reset release: the first push can occur on the first rising edge after `Reset_n` goes high.
- Latency: an index pushed at edge N appears on `Out` with `Out_Valid` = 1 after edge N, and can be popped at edge N+1.
- Throughput: one push and one pop per cycle when steady. Full rate is sustained in state ONE.
- Backpressure: `Out_Ready` low for 2+ cycles with continuous input gives FULL and then `In_Ready` = 0. Throughput is limited to one item per cycle.
- Reset mid-operation: all buffered entries and `Mask` are discarded immediately. Nothing is emitted afterward until new pushes arrive.
- `Mask` reflects a pop at edge N from after edge N.

## Structure
- Shared package `priority_pkg` holds:
  - `IN_W`/`OUT_W` constants, shared with the encoder.
  - The FIFO state enum: EMPTY, ONE, FULL.
  - A `onehot_decode` function (IN_W to OUT_W).
- Sub-module `dec_fifo2`: a generic 2-entry, IN_W-wide valid/ready FIFO holding state, pointers and storage.
- The top level holds the decode, the `Enable` gating and the `Mask` register.

## Test plan
- Reset, then with `Enable` = 1 and `Out_Ready` = 1, push `In` = 5 → after one edge `Out` = 8'b0010_0000 and `Out_Valid` = 1. After the next edge `Mask` = 8'b0010_0000 and `Out_Valid` = 0.
- `Out_Ready` = 0, push 0 then 7 → state FULL, `In_Ready` = 0. A third offered index (3) is not accepted. Raising `Out_Ready` yields `Out` = 8'h01 then 8'h80, then empty.
- Stream 0..7 back-to-back with `Out_Ready` = 1 → eight consecutive one-hot words in order, no bubbles, and final `Mask` = 8'hFF.
- `Mask` = 8'hFF, then `Mask_Clear` together with a pop of index 2 → `Mask` = 8'h04. `Mask_Clear` alone → `Mask` = 8'h00.
- Two entries buffered, `Enable` dropped → `In_Ready` = 0, and both entries are still delivered in order.
- Two entries buffered, `Reset_n` pulsed low mid-cycle → `Out_Valid`, `Out` and `Mask` go to 0 immediately, with no stale output after release.
